prog_mem_responder: RTL and testbench
=====================================

Name: prog_mem_responder

Overview:
- Responder side of the core's memory interface: a 16x8 program/data memory that serves fetch, load and store requests over a req/ack handshake.
- Owns a byte-stream loader port. An external source downloads a program into the memory starting at address 0 before or between CPU runs.
- Sits between the 8-bit core and the program source; replaces hard-coded memory initialisation.

Parameters:
- DEPTH, 16, number of memory entries; must equal 2**AW.
- AW, 4, address width.
- DW, 8, data width.
- WAIT_CYCLES, 1, extra cycles between request sampling and ack; 0 is legal.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU request; held high by CPU until cpu_ack.
- cpu_we  in  1  1 = store, 0 = read (fetch/load).
- cpu_addr  in  AW  request address.
- cpu_wdata  in  DW  store data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  read data; valid in the ack cycle, held until the next read ack.
- load_start  in  1  pulse: begin download at address 0.
- load_valid  in  1  loader byte valid.
- load_data  in  DW  loader byte.
- load_ready  out  1  responder accepts a loader byte this cycle.
- load_done  out  1  all DEPTH bytes written; held until the next load_start or reset.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All memory entries are cleared to 8'h00, which decodes as HALT/NOP.
  - cpu_ack, cpu_rdata, load_ready, load_done and busy all go to 0; the load pointer goes to 0.
  - Reset during any state aborts the transaction with no partial commit.
- States: IDLE, LOAD, WAIT, ACK.
- IDLE:
  - load_start=1: go to LOAD, pointer to 0, load_done to 0. load_start wins over a simultaneous cpu_req.
  - Otherwise, cpu_req=1: latch addr, we and wdata. Go to WAIT with counter=WAIT_CYCLES, or directly to ACK if WAIT_CYCLES=0.
- WAIT:
  - Counter decrements each cycle; go to ACK when it reaches 0.
  - Inputs are not re-sampled.
- ACK entry edge:
  - Stores commit mem[addr]<=wdata.
  - Reads register cpu_rdata<=mem[addr]; stores leave cpu_rdata unchanged.
  - cpu_ack is high for exactly this one ACK cycle, then state returns to IDLE.
- Latency: request sampled in IDLE at cycle N; cpu_ack is high in cycle N+1+WAIT_CYCLES.
- Back-to-back requests: a cpu_req still high in the IDLE cycle after ack starts a new transaction. The CPU must drop or update req in the ack cycle.
- LOAD:
  - load_ready is registered and goes high the cycle after load_start is sampled.
  - On each cycle with load_valid && load_ready: mem[ptr]<=load_data, ptr<=ptr+1.
  - Gaps in load_valid are allowed.
  - After accepting entry DEPTH-1: load_ready<=0, load_done<=1, state to IDLE.
  - load_start during LOAD restarts at pointer 0.
  - cpu_req during LOAD stays pending, is not acked, and is served from IDLE after the load finishes.
- Pointer arithmetic is AW bits and wraps naturally. Completion is detected on ptr==DEPTH-1 with acceptance, never on wrap.
- load_valid outside LOAD is ignored; no memory write occurs.

Test Plan:
- Reset then read: release rst_n, cpu_req read addr 13, WAIT_CYCLES=1 -> cpu_ack exactly 2 cycles after request sampling, cpu_rdata=8'h00, busy high for those 2 cycles.
- Full download: load_start, then 16 bytes 8'h2E,8'h1F,8'h84,8'hA2,8'h00 x10,8'h01,8'h01 -> load_done=1 after 16th accept, load_ready=0. Reads: addr 2 -> 8'h84, addr 15 -> 8'h01.
- Loader gaps: load_valid toggled every other cycle with bytes 0..15 -> exactly 16 writes, addr k reads k, load_done after last byte only.
- Store/read back: store 8'h5A to addr 13, then read addr 13 -> 8'h5A. Each cpu_ack is a single-cycle pulse. cpu_rdata after the store still shows the prior read value.
- Collision: load_start and cpu_req (read addr 0) in the same IDLE cycle -> load runs first, no ack before load_done, then read returns the first loaded byte.
- Reset mid-load: assert rst_n=0 after 5 accepted bytes -> load_ready=0, load_done=0, busy=0 immediately; subsequent reads of addr 0..4 return 8'h00.

Source files
------------

// File: rtl/prog_mem_responder.sv
// ============================================================================
// Module      : prog_mem_responder
// Description : 16x8 program/data memory serving the core's fetch, load and
//               store requests over a req/ack handshake, with a byte-stream
//               loader port that downloads a program starting at address 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_responder #(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [DW-1:0] load_data,
  output logic          load_ready,
  output logic          load_done,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // Counter is at least one bit wide so WAIT_CYCLES=0 still elaborates.
  localparam int              c_CW        = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [c_CW-1:0] c_WAIT_INIT = c_CW'(WAIT_CYCLES);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [AW-1:0]   c_LAST      = AW'(DEPTH - 1);

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_ptr;
  logic [c_CW-1:0] r_cnt;
  logic            r_we;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic            r_ack;
  logic [DW-1:0]   r_rdata;
  logic            r_load_ready;
  logic            r_load_done;
  logic            r_busy;

  // Control FSM, memory array and all registered outputs. The memory is
  // cleared by reset so an un-downloaded program decodes as HALT/NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
      r_busy       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // ack is a single-cycle pulse unless re-asserted below
      r_ack <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          // a download request takes priority over a pending CPU access
          if (load_start) begin
            r_state      <= S_LOAD;
            r_ptr        <= '0;
            r_load_done  <= 1'b0;
            r_load_ready <= 1'b1;
            r_busy       <= 1'b1;
          end else if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_busy  <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              // zero wait: this edge is the ACK entry edge, commit directly
              r_state <= S_ACK;
              r_ack   <= 1'b1;
              if (cpu_we) begin
                r_mem[cpu_addr] <= cpu_wdata;
              end else begin
                r_rdata <= r_mem[cpu_addr];
              end
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= c_WAIT_INIT;
            end
          end
        end
        S_LOAD: begin
          if (load_start) begin
            r_ptr <= '0;
          end else if (load_valid && r_load_ready) begin
            r_mem[r_ptr] <= load_data;
            r_ptr        <= r_ptr + AW'(1);
            // completion keys off the last index, not the pointer wrap
            if (r_ptr == c_LAST) begin
              r_load_ready <= 1'b0;
              r_load_done  <= 1'b1;
              r_state      <= S_IDLE;
              r_busy       <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - c_CNT_ONE;
          if (r_cnt <= c_CNT_ONE) begin
            // edge into ACK: commit store or capture read data
            r_state <= S_ACK;
            r_ack   <= 1'b1;
            if (r_we) begin
              r_mem[r_addr] <= r_wdata;
            end else begin
              r_rdata <= r_mem[r_addr];
            end
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_ack    = r_ack;
  assign cpu_rdata  = r_rdata;
  assign load_ready = r_load_ready;
  assign load_done  = r_load_done;
  assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_responder.sv
// ============================================================================
// Module      : tb_prog_mem_responder
// Description : Self-checking bench for prog_mem_responder. Stimulus pushes
//               expected read data into a queue; a monitor pops and compares
//               on every cpu_ack. A plain array models the memory contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_mem_responder;

  localparam int TB_WAIT = 1;

  logic       clk;
  logic       rst_n;
  logic       cpu_req;
  logic       cpu_we;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       busy;

  int tests;
  int fails;

  // reference model: memory image, last read value, expected ack data
  logic [7:0] model_mem [16];
  logic [7:0] model_rdata;
  logic [7:0] exp_q [$];
  logic [7:0] ld_bytes [16];
  logic [7:0] mon_exp;

  prog_mem_responder #(
    .DEPTH(16), .AW(4), .DW(8), .WAIT_CYCLES(TB_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every ack must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && cpu_ack) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack with no outstanding request, required none (t=%0t)", $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, mon_exp});
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    model_rdata = 8'h00;
  endtask

  // one CPU access; optional noise on the loader port, which must be ignored
  task automatic cpu_op(input bit we, input logic [3:0] a, input logic [7:0] d, input bit noise);
    int n;
    bit busy_low;
    @(negedge clk);
    if (we) begin
      exp_q.push_back(model_rdata);
      model_mem[a] = d;
    end else begin
      model_rdata = model_mem[a];
      exp_q.push_back(model_rdata);
    end
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    if (noise) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom);
    end
    n = 0;
    busy_low = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) busy_low = 1'b1;
    end while (!cpu_ack && n < 50);
    check("ack_latency", n, TB_WAIT + 1);
    check("busy_during_access", busy_low, 0);
    cpu_req    = 1'b0;
    load_valid = 1'b0;
    @(negedge clk);
    check("ack_single_pulse", cpu_ack, 0);
    check("busy_after_access", busy, 0);
  endtask

  // mode 0: dense, 1: every other cycle, 2: random gaps
  task automatic do_load(input int mode, input bit with_req, input int abort_after);
    int idx, t, n;
    bit v, rdy, done_early, ack_early, aborted;
    idx = 0; t = 0; done_early = 0; ack_early = 0; aborted = 0;
    @(negedge clk);
    load_start = 1'b1;
    if (with_req) begin
      cpu_req  = 1'b1;
      cpu_we   = 1'b0;
      cpu_addr = 4'd0;
      model_rdata = ld_bytes[0];
      exp_q.push_back(model_rdata);
    end
    @(negedge clk);
    load_start = 1'b0;
    while (idx < 16 && t < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 0);
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      load_valid = v;
      load_data  = ld_bytes[idx];
      rdy = load_ready;
      if (load_done) done_early = 1'b1;
      if (cpu_ack) ack_early = 1'b1;
      @(negedge clk);
      t++;
      if (v && rdy) idx++;
      if (abort_after >= 0 && idx == abort_after) begin
        aborted = 1'b1;
        break;
      end
    end
    load_valid = 1'b0;
    if (aborted) begin
      rst_n = 1'b0;
      #1;
      check("abort_load_ready", load_ready, 0);
      check("abort_load_done", load_done, 0);
      check("abort_busy", busy, 0);
      model_clear();
      return;
    end
    check("load_accepts", idx, 16);
    check("load_done_set", load_done, 1);
    check("load_ready_cleared", load_ready, 0);
    check("busy_after_load", busy, 0);
    check("load_done_early", done_early, 0);
    for (int i = 0; i < 16; i++) model_mem[i] = ld_bytes[i];
    if (with_req) begin
      check("ack_during_load", ack_early, 0);
      n = 0;
      while (!cpu_ack && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("pending_req_acked", cpu_ack, 1);
      cpu_req = 1'b0;
      @(negedge clk);
    end
  endtask

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    load_start = 1'b0; load_valid = 1'b0; load_data = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_ack", cpu_ack, 0);
    check("reset_rdata", cpu_rdata, 0);
    check("reset_load_ready", load_ready, 0);
    check("reset_load_done", load_done, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;

    // read of a cleared location
    cpu_op(1'b0, 4'd13, 8'h00, 1'b0);

    // full dense download of a fixed program
    ld_bytes[0] = 8'h2E; ld_bytes[1] = 8'h1F; ld_bytes[2] = 8'h84; ld_bytes[3] = 8'hA2;
    for (int i = 4; i < 14; i++) ld_bytes[i] = 8'h00;
    ld_bytes[14] = 8'h01; ld_bytes[15] = 8'h01;
    do_load(0, 1'b0, -1);
    cpu_op(1'b0, 4'd2, 8'h00, 1'b0);
    cpu_op(1'b0, 4'd15, 8'h00, 1'b0);

    // store then read back; store ack must keep the previous read data
    cpu_op(1'b1, 4'd13, 8'h5A, 1'b0);
    cpu_op(1'b0, 4'd13, 8'h00, 1'b0);

    // loader with gaps, bytes equal to their address
    for (int i = 0; i < 16; i++) ld_bytes[i] = 8'(i);
    do_load(1, 1'b0, -1);
    for (int i = 0; i < 16; i++) cpu_op(1'b0, 4'(i), 8'h00, 1'b0);

    // load_start and read request in the same idle cycle
    for (int i = 0; i < 16; i++) ld_bytes[i] = 8'($urandom);
    do_load(2, 1'b1, -1);

    // reset after 5 accepted bytes
    for (int i = 0; i < 16; i++) ld_bytes[i] = 8'($urandom_range(1, 255));
    do_load(0, 1'b0, 5);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cpu_op(1'b0, 4'(i), 8'h00, 1'b0);

    // randomized mix of accesses and downloads
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 9) < 8) begin
        cpu_op($urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom), $urandom_range(0, 1) == 1);
      end else begin
        for (int i = 0; i < 16; i++) ld_bytes[i] = 8'($urandom);
        do_load(2, $urandom_range(0, 1) == 1, -1);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
